rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter with a busy-register scoreboard: grants one writeback per cycle and tracks pending writes.
// Define RF_WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module rf_wb_arbiter #(
    parameter int NREQ       = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [5*NREQ-1:0]          req_addr,
    input  logic [DATA_WIDTH*NREQ-1:0] req_data,
    output logic                       rf_wen,
    output logic [4:0]                 rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    input  logic                       issue_valid,
    input  logic [4:0]                 issue_rd,
    output logic                       issue_ready,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    output logic                       raw_stall,
    input  logic                       flush,
    output logic [31:0]                busy
);
    // Handshake on requester i: req_valid[i] & req_ready[i] in the same cycle.
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [NREQ-1:0]       cand;
    logic [NREQ-1:0]       grant;
    logic                  handshake;
    logic [4:0]            sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [31:0]           busy_next;

`ifdef RF_WB_ARB_ROUND_ROBIN_EN
    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [NREQ-1:0]  upper;

    // Requesters at or above the pointer go first; wrap to the full set if none.
    always_comb begin
        upper = req_valid & ~((ONE << ptr) - ONE);
        cand  = (upper != '0) ? upper : req_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (handshake) begin
            ptr <= ptr_next;
        end
    end
`else
    assign cand = req_valid;
`endif

    // Isolate the lowest set bit of the candidate set.
    assign grant     = cand & (~cand + ONE);
    assign req_ready = grant;
    assign handshake = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
        ptr_next = ptr;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*5 +: 5];
                sel_data = sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef RF_WB_ARB_ROUND_ROBIN_EN
                ptr_next = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
`endif
            end
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= handshake && (sel_addr != 5'd0);
            if (handshake && (sel_addr != 5'd0)) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

    assign issue_ready = (issue_rd == 5'd0) || !busy[issue_rd];
    assign raw_stall   = ((rs1 != 5'd0) && busy[rs1]) || ((rs2 != 5'd0) && busy[rs2]);

    // Clear first so a same-cycle set wins; flush overrides both.
    always_comb begin
        busy_next = busy;
        if (rf_wen) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != 5'd0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule
